// File: rtl/mem_pkg.sv
// mem_pkg: op codes, exception codes, FSM states and access-size helpers for the memory access unit
package mem_pkg;
  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [1:0] EXC_MIS_LD  = 2'd0;
  localparam logic [1:0] EXC_MIS_ST  = 2'd1;
  localparam logic [1:0] EXC_BUS     = 2'd2;
  localparam logic [1:0] EXC_TIMEOUT = 2'd3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;
  function automatic mem_size_e op_size(input logic [3:0] op);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return SZ_H;
    if (op == OP_LW || op == OP_SW) return SZ_W;
    return SZ_B;
  endfunction
  function automatic logic op_store(input logic [3:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction
  function automatic logic op_signed(input logic [3:0] op);
    return op == OP_LB || op == OP_LH;
  endfunction
  function automatic int lane_idx(input int nb, input int off);
    return nb - 1 - off;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian byte-lane select, store replication and load extract/extend
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int LW = $clog2(NB)
) (
  input  logic [3:0]        op,
  input  logic [LW-1:0]     off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     sel,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext
);
  mem_size_e sz;
  logic [LW-1:0] bl, hl;
  logic [DATA_W-1:0] rb, rh;
  assign sz = op_size(op);
  assign bl = LW'(lane_idx(NB, int'(off)));
  assign hl = bl - LW'(1);
  assign rb = rdata >> {bl, 3'b000};
  assign rh = rdata >> {hl, 3'b000};
  // lane select, replicated store data and extended load data for the current op
  always_comb begin
    sel = sz == SZ_W ? '1 : sz == SZ_H ? NB'(3) << hl : NB'(1) << bl;
    wdata_rep = sz == SZ_W ? wdata : sz == SZ_H ? {(NB/2){wdata[15:0]}} : {NB{wdata[7:0]}};
    rdata_ext = op_store(op) || op == OP_NONE ? '0 :
                sz == SZ_W ? rdata :
                sz == SZ_H ? {{(DATA_W-16){op_signed(op) & rh[15]}}, rh[15:0]} :
                {{(DATA_W-8){op_signed(op) & rb[7]}}, rb[7:0]};
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store unit driving a req/ack bus with stall, flush and exceptions
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 15,
  localparam int NB = DATA_W / 8,
  localparam int LW = $clog2(NB),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [NB-1:0]     bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              stall_req_o,
  output logic              done_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              exc_o,
  output logic [1:0]        exc_code_o,
  output logic [ADDR_W-1:0] bad_addr_o
);
  logic [1:0] state;
  logic [3:0] op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, wrep, rext;
  logic [NB-1:0] sel;
  logic [CW-1:0] cnt;
  logic flush_q, accept, mis, in_bus, tmo, sup;
  mem_size_e sz_i;
  assign sz_i = op_size(mem_op_i);
  assign accept = state == S_IDLE && req_valid_i && mem_op_i != OP_NONE && !flush_i;
  assign mis = sz_i == SZ_H ? addr_i[0] : sz_i == SZ_W ? |addr_i[LW-1:0] : 1'b0;
  assign in_bus = state == S_BUS;
  assign tmo = cnt == CW'(TIMEOUT - 1);
  assign sup = flush_q | flush_i;
  assign stall_req_o = accept | in_bus;
  assign done_o = state == S_FIN && !flush_q && !flush_i;
  assign bus_req_o = in_bus;
  assign bus_we_o = in_bus & op_store(op_q);
  assign bus_sel_o = in_bus ? sel : '0;
  assign bus_addr_o = in_bus ? {addr_q[ADDR_W-1:LW], LW'(0)} : '0;
  assign bus_wdata_o = in_bus ? wrep : '0;
  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .op(op_q),
    .off(addr_q[LW-1:0]),
    .wdata(wdata_q),
    .rdata(bus_rdata_i),
    .sel(sel),
    .wdata_rep(wrep),
    .rdata_ext(rext)
  );
  // control FSM, request capture, bus cycle counter and sticky flush flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op_q <= OP_NONE;
      addr_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      flush_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          flush_q <= 1'b0;
          if (accept) begin
            op_q <= mem_op_i;
            addr_q <= addr_i;
            wdata_q <= wdata_i;
            cnt <= '0;
            state <= mis ? S_FIN : S_BUS;
          end
        end
        S_BUS: begin
          flush_q <= sup;
          if (bus_err_i || bus_ack_i || tmo) state <= S_FIN;
          else cnt <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  // completion results, written on entry to FIN unless the access was flushed
  always_ff @(posedge clk) begin
    if (rst) begin
      load_data_o <= '0;
      exc_o <= 1'b0;
      exc_code_o <= '0;
      bad_addr_o <= '0;
    end else if (accept && mis) begin
      load_data_o <= '0;
      exc_o <= 1'b1;
      exc_code_o <= op_store(mem_op_i) ? EXC_MIS_ST : EXC_MIS_LD;
      bad_addr_o <= addr_i;
    end else if (in_bus && !sup) begin
      if (bus_err_i || (!bus_ack_i && tmo)) begin
        load_data_o <= '0;
        exc_o <= 1'b1;
        exc_code_o <= bus_err_i ? EXC_BUS : EXC_TIMEOUT;
        bad_addr_o <= addr_q;
      end else if (bus_ack_i) begin
        load_data_o <= rext;
        exc_o <= 1'b0;
      end
    end
  end
endmodule
